// File: rtl/regfile_write_ctrl_if.sv
// Bundle of the register-file write-port signals: CPU writeback, debug/loader
// valid/ready request, init control/status and the outgoing write port.
// master: the surrounding system (CPU, debug requester, register file).
// slave : regfile_write_ctrl, which owns the write port.
interface regfile_write_ctrl_if;
    logic        init_req;
    logic        cpu_we;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_wdata;
    logic        dbg_valid;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        cpu_stall;
    logic        init_done;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    modport master (
        output init_req, cpu_we, cpu_rd, cpu_wdata, dbg_valid, dbg_rd, dbg_wdata,
        input  dbg_ready, cpu_stall, init_done, rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  init_req, cpu_we, cpu_rd, cpu_wdata, dbg_valid, dbg_rd, dbg_wdata,
        output dbg_ready, cpu_stall, init_done, rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller.
// After reset it sweeps x1..x31 (x2 gets SP_INIT, the rest 0), then arbitrates
// the single write port between CPU writeback (priority) and a debug/loader
// requester. A starvation guard inserts a one-cycle CPU stall after
// STARVE_LIMIT consecutive CPU-blocked debug cycles so debug always completes.
// Optional macro REGCTRL_TRACE_EN adds wr_count/last_rd trace outputs.
module regfile_write_ctrl #(
    parameter logic [31:0] SP_INIT      = 32'd4092,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_ctrl_if.slave  bus
`ifdef REGCTRL_TRACE_EN
    ,
    output logic [15:0]          wr_count,
    output logic [4:0]           last_rd
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    state_t      state_r;
    logic [4:0]  init_idx_r;
    logic [3:0]  starve_cnt_r;

    logic        cpu_hit_s;
    logic        starve_hit_s;
    logic        rf_we_s;
    logic [4:0]  rf_rd_s;
    logic [31:0] rf_wdata_s;
    logic        dbg_ready_s;
    logic        cpu_stall_s;
    logic        init_done_s;

    // A CPU write to x0 is a no-op and must never block the debug requester.
    assign cpu_hit_s    = bus.cpu_we && (bus.cpu_rd != 5'd0);
    assign starve_hit_s = cpu_hit_s && bus.dbg_valid && (starve_cnt_r == STARVE_LAST);

    // Write-port mux and handshake decode; everything held quiet while in reset.
    always_comb begin
        rf_we_s     = 1'b0;
        rf_rd_s     = 5'd0;
        rf_wdata_s  = 32'd0;
        dbg_ready_s = 1'b0;
        cpu_stall_s = 1'b1;
        init_done_s = 1'b0;
        if (!rst_n) begin
            cpu_stall_s = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rf_we_s    = 1'b1;
                    rf_rd_s    = init_idx_r;
                    rf_wdata_s = (init_idx_r == 5'd2) ? SP_INIT : 32'd0;
                end
                ST_RUN: begin
                    cpu_stall_s = 1'b0;
                    init_done_s = 1'b1;
                    if (cpu_hit_s) begin
                        rf_we_s    = 1'b1;
                        rf_rd_s    = bus.cpu_rd;
                        rf_wdata_s = bus.cpu_wdata;
                    end else if (bus.dbg_valid) begin
                        dbg_ready_s = 1'b1;
                        rf_we_s     = (bus.dbg_rd != 5'd0);
                        rf_rd_s     = bus.dbg_rd;
                        rf_wdata_s  = bus.dbg_wdata;
                    end else begin
                        rf_we_s = 1'b0;
                    end
                end
                ST_STALL: begin
                    // CPU write dropped here; the CPU re-presents it next cycle.
                    init_done_s = 1'b1;
                    dbg_ready_s = 1'b1;
                    rf_we_s     = (bus.dbg_rd != 5'd0);
                    rf_rd_s     = bus.dbg_rd;
                    rf_wdata_s  = bus.dbg_wdata;
                end
                default: begin
                    rf_we_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_we     = rf_we_s;
    assign bus.rf_rd     = rf_rd_s;
    assign bus.rf_wdata  = rf_wdata_s;
    assign bus.dbg_ready = dbg_ready_s;
    assign bus.cpu_stall = cpu_stall_s;
    assign bus.init_done = init_done_s;

    // Sequencer: init sweep, run-mode arbitration and starvation counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            init_idx_r   <= 5'd1;
            starve_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    starve_cnt_r <= 4'd0;
                    if (init_idx_r == 5'd31) begin
                        state_r    <= ST_RUN;
                        init_idx_r <= 5'd1;
                    end else begin
                        init_idx_r <= init_idx_r + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.init_req) begin
                        state_r      <= ST_INIT;
                        init_idx_r   <= 5'd1;
                        starve_cnt_r <= 4'd0;
                    end else if (starve_hit_s) begin
                        state_r      <= ST_STALL;
                        starve_cnt_r <= 4'd0;
                    end else if (cpu_hit_s && bus.dbg_valid) begin
                        starve_cnt_r <= starve_cnt_r + 4'd1;
                    end else begin
                        // Debug granted or idle: blocked streak is broken.
                        starve_cnt_r <= 4'd0;
                    end
                end
                ST_STALL: begin
                    state_r      <= ST_RUN;
                    starve_cnt_r <= 4'd0;
                end
                default: begin
                    state_r      <= ST_INIT;
                    init_idx_r   <= 5'd1;
                    starve_cnt_r <= 4'd0;
                end
            endcase
        end
    end

`ifdef REGCTRL_TRACE_EN
    // Trace of run-mode writes; cleared whenever a new sweep is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= 16'd0;
            last_rd  <= 5'd0;
        end else if ((state_r == ST_RUN) && bus.init_req) begin
            wr_count <= 16'd0;
            last_rd  <= 5'd0;
        end else if (rf_we_s && (state_r != ST_INIT)) begin
            wr_count <= wr_count + 16'd1;
            last_rd  <= rf_rd_s;
        end else begin
            wr_count <= wr_count;
            last_rd  <= last_rd;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed testbench for regfile_write_ctrl (default build, trace disabled).
// Inputs are driven on the falling edge, outputs sampled 1 ns later; a small
// register-file model captures rf_* on the rising edge.
module tb_regfile_write_ctrl;
    logic clk;
    logic rst_n;
    regfile_write_ctrl_if bus();

    int n_checks;
    int n_errors;
    logic [31:0] rf_model [32];

    regfile_write_ctrl #(.SP_INIT(32'd4092), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures the write port on the rising edge.
    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) rf_model[bus.rf_rd] <= bus.rf_wdata;
    end

    task automatic idle();
        bus.init_req  = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_rd    = 5'd0;
        bus.cpu_wdata = 32'd0;
        bus.dbg_valid = 1'b0;
        bus.dbg_rd    = 5'd0;
        bus.dbg_wdata = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we); end
        n_checks++; if (bus.rf_rd !== 5'd0) begin n_errors++; $display("FAIL reset_rf_rd got %0d want 0", bus.rf_rd); end
        n_checks++; if (bus.rf_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_rf_wdata got %h want 0", bus.rf_wdata); end
        n_checks++; if (bus.dbg_ready !== 1'b0) begin n_errors++; $display("FAIL reset_dbg_ready got %0b want 0", bus.dbg_ready); end
        n_checks++; if (bus.cpu_stall !== 1'b1) begin n_errors++; $display("FAIL reset_cpu_stall got %0b want 1", bus.cpu_stall); end
        n_checks++; if (bus.init_done !== 1'b0) begin n_errors++; $display("FAIL reset_init_done got %0b want 0", bus.init_done); end
    endtask

    task automatic test_init_sweep();
        logic [31:0] exp_d;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 31; c++) begin
            exp_d = (c == 2) ? 32'd4092 : 32'd0;
            n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(c) || bus.rf_wdata !== exp_d) begin
                n_errors++; $display("FAIL sweep_cycle%0d got we=%0b rd=%0d d=%h want we=1 rd=%0d d=%h", c, bus.rf_we, bus.rf_rd, bus.rf_wdata, c, exp_d);
            end
            n_checks++; if (bus.cpu_stall !== 1'b1 || bus.init_done !== 1'b0) begin
                n_errors++; $display("FAIL sweep_status%0d got stall=%0b done=%0b want stall=1 done=0", c, bus.cpu_stall, bus.init_done);
            end
            @(negedge clk);
            #1;
        end
        n_checks++; if (bus.init_done !== 1'b1 || bus.cpu_stall !== 1'b0) begin
            n_errors++; $display("FAIL sweep_done got done=%0b stall=%0b want done=1 stall=0", bus.init_done, bus.cpu_stall);
        end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_errors++; $display("FAIL run_idle_we got %0b want 0", bus.rf_we); end
        n_checks++; if (rf_model[2] !== 32'd4092) begin n_errors++; $display("FAIL sweep_x2 got %h want %h", rf_model[2], 32'd4092); end
        n_checks++; if (rf_model[1] !== 32'd0 || rf_model[31] !== 32'd0 || rf_model[17] !== 32'd0) begin
            n_errors++; $display("FAIL sweep_clear got x1=%h x17=%h x31=%h want 0", rf_model[1], rf_model[17], rf_model[31]);
        end
        n_checks++; if (rf_model[0] !== 32'd0) begin n_errors++; $display("FAIL sweep_x0 got %h want 0", rf_model[0]); end
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd5; bus.cpu_wdata = 32'hA5A5_A5A5;
        #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hA5A5_A5A5 || bus.dbg_ready !== 1'b0) begin
            n_errors++; $display("FAIL cpu_write got we=%0b rd=%0d d=%h rdy=%0b want 1/5/a5a5a5a5/0", bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.dbg_ready);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (rf_model[5] !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL cpu_x5 got %h want a5a5a5a5", rf_model[5]); end
    endtask

    task automatic test_dbg_write();
        @(negedge clk);
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd7; bus.dbg_wdata = 32'h1234_5678;
        #1;
        n_checks++; if (bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'h1234_5678) begin
            n_errors++; $display("FAIL dbg_write got rdy=%0b we=%0b rd=%0d d=%h want 1/1/7/12345678", bus.dbg_ready, bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (rf_model[7] !== 32'h1234_5678) begin n_errors++; $display("FAIL dbg_x7 got %h want 12345678", rf_model[7]); end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.cpu_we = 1'b1; bus.cpu_rd = 5'd3; bus.cpu_wdata = 32'h3000_0000 + 32'(k);
            bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd9; bus.dbg_wdata = 32'hDEAD_BEEF;
            #1;
            n_checks++; if (bus.cpu_stall !== 1'b0 || bus.dbg_ready !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'h3000_0000 + 32'(k)) begin
                n_errors++; $display("FAIL starve_cpu%0d got stall=%0b rdy=%0b rd=%0d d=%h want 0/0/3/%h", k, bus.cpu_stall, bus.dbg_ready, bus.rf_rd, bus.rf_wdata, 32'h3000_0000 + 32'(k));
            end
        end
        @(negedge clk);
        bus.cpu_wdata = 32'h3000_0004;
        #1;
        n_checks++; if (bus.cpu_stall !== 1'b1 || bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd9 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL starve_stall got stall=%0b rdy=%0b we=%0b rd=%0d d=%h want 1/1/1/9/deadbeef", bus.cpu_stall, bus.dbg_ready, bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        bus.dbg_valid = 1'b0;
        #1;
        n_checks++; if (bus.cpu_stall !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'h3000_0004) begin
            n_errors++; $display("FAIL starve_resume got stall=%0b rd=%0d d=%h want 0/3/30000004", bus.cpu_stall, bus.rf_rd, bus.rf_wdata);
        end
        n_checks++; if (rf_model[9] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL starve_x9 got %h want deadbeef", rf_model[9]); end
        n_checks++; if (rf_model[3] !== 32'h3000_0003) begin n_errors++; $display("FAIL starve_x3_held got %h want 30000003", rf_model[3]); end
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (rf_model[3] !== 32'h3000_0004) begin n_errors++; $display("FAIL starve_x3_replay got %h want 30000004", rf_model[3]); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd0; bus.dbg_wdata = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            n_errors++; $display("FAIL dbg_x0 got rdy=%0b we=%0b want 1/0", bus.dbg_ready, bus.rf_we);
        end
        @(negedge clk);
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd0; bus.cpu_wdata = 32'h5555_5555;
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd11; bus.dbg_wdata = 32'h0B0B_0B0B;
        #1;
        n_checks++; if (bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd11 || bus.rf_wdata !== 32'h0B0B_0B0B) begin
            n_errors++; $display("FAIL cpu_x0_dbg got rdy=%0b we=%0b rd=%0d d=%h want 1/1/11/0b0b0b0b", bus.dbg_ready, bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (rf_model[0] !== 32'd0) begin n_errors++; $display("FAIL x0_kept got %h want 0", rf_model[0]); end
        n_checks++; if (rf_model[11] !== 32'h0B0B_0B0B) begin n_errors++; $display("FAIL x11 got %h want 0b0b0b0b", rf_model[11]); end
    endtask

    task automatic test_init_req();
        int n;
        @(negedge clk);
        bus.init_req = 1'b1;
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd6; bus.cpu_wdata = 32'h0000_0066;
        #1;
        n_checks++; if (bus.init_done !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd6) begin
            n_errors++; $display("FAIL init_req_cycle got done=%0b we=%0b rd=%0d want 1/1/6", bus.init_done, bus.rf_we, bus.rf_rd);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++; if (bus.init_done !== 1'b0 || bus.rf_rd !== 5'd1) begin
            n_errors++; $display("FAIL init_req_restart got done=%0b rd=%0d want 0/1", bus.init_done, bus.rf_rd);
        end
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        n_checks++; if (n != 31) begin n_errors++; $display("FAIL init_req_len got %0d want 31", n); end
        n_checks++; if (rf_model[5] !== 32'd0 || rf_model[6] !== 32'd0) begin
            n_errors++; $display("FAIL init_req_x5 got x5=%h x6=%h want 0", rf_model[5], rf_model[6]);
        end
        n_checks++; if (rf_model[2] !== 32'd4092) begin n_errors++; $display("FAIL init_req_x2 got %h want %h", rf_model[2], 32'd4092); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        @(negedge clk);
        bus.init_req = 1'b1;
        @(negedge clk);
        bus.init_req = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        n_checks++; if (bus.rf_rd !== 5'd10) begin n_errors++; $display("FAIL mid_sweep_idx got %0d want 10", bus.rf_rd); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.cpu_stall !== 1'b1 || bus.init_done !== 1'b0 || bus.dbg_ready !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_out got we=%0b rd=%0d d=%h stall=%0b done=%0b rdy=%0b want 0/0/0/1/0/0", bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.cpu_stall, bus.init_done, bus.dbg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd1 || bus.rf_wdata !== 32'd0) begin
            n_errors++; $display("FAIL mid_reset_restart got we=%0b rd=%0d d=%h want 1/1/0", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        n_checks++; if (n != 31) begin n_errors++; $display("FAIL mid_reset_len got %0d want 31", n); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rf_model[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf_model[i] = 32'hBAD0_0000 + 32'(i);
        test_reset();
        test_init_sweep();
        test_cpu_write();
        test_dbg_write();
        test_starvation();
        test_x0();
        test_init_req();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
